// File: rtl/pwm_bank_if.sv
// Control/status bundle for pwm_bank: enable, period, duty write port and PWM outputs.
// The controller side drives through master; pwm_bank itself connects through slave.
interface pwm_bank_if #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int CHW      = 2
);
    logic                en;
    logic [WIDTH-1:0]    period;
    logic                duty_wr;
    logic [CHW-1:0]      duty_ch;
    logic [WIDTH-1:0]    duty_data;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;

    modport master (
        output en, period, duty_wr, duty_ch, duty_data,
        input  pwm_out, period_start
    );

    modport slave (
        input  en, period, duty_wr, duty_ch, duty_data,
        output pwm_out, period_start
    );
endinterface

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one counter, with shadow/active duty registers.
// Define PWM_BANK_CENTER_EN for center-aligned (up/down) counting; edge-aligned otherwise.
module pwm_bank #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int CHW      = 2
) (
    input  logic         clk,
    input  logic         rst,
    pwm_bank_if.slave    bus
);
    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    cnt_nxt;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [CHANNELS-1:0] pwm_q;
    logic                ps_q;
    logic                wrap;
    logic                start_evt;

`ifdef PWM_BANK_CENTER_EN
    // dir = 1 while counting down; it drops back to 0 as the count lands on 0,
    // so cnt == 0 with dir == 0 is the valley.
    logic dir;
    logic dir_nxt;

    always_comb begin
        wrap      = (cnt == '0) && !dir;
        start_evt = bus.en && wrap;
        cnt_nxt   = cnt;
        dir_nxt   = dir;
        if (!bus.en || bus.period == '0) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end else if (!dir) begin
            if (cnt >= bus.period) begin
                cnt_nxt = cnt - WIDTH'(1);
                dir_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end else if (cnt <= WIDTH'(1)) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
        end else begin
            cnt_nxt = cnt - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir <= 1'b0;
        end else begin
            dir <= dir_nxt;
        end
    end
`else
    // >= rather than == so a period lowered below cnt wraps immediately.
    always_comb begin
        wrap      = (cnt >= bus.period);
        start_evt = bus.en && (cnt == '0);
        cnt_nxt   = cnt + WIDTH'(1);
        if (!bus.en || wrap) begin
            cnt_nxt = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            pwm_q <= '0;
            ps_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            cnt  <= cnt_nxt;
            ps_q <= start_evt;
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.duty_wr && (int'(bus.duty_ch) == i)) begin
                    shadow[i] <= bus.duty_data;
                end
                // Non-blocking read of shadow: a same-cycle write lands one period later.
                if (!bus.en || wrap) begin
                    active[i] <= shadow[i];
                end
                pwm_q[i] <= bus.en && (cnt < active[i]);
            end
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = ps_q;
endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank (4 channels, 10-bit, 3-bit channel select).
// Covers the edge-aligned build by default and the center-aligned build under PWM_BANK_CENTER_EN.
module tb_pwm_bank;
    localparam int W  = 10;
    localparam int CH = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;

    pwm_bank_if #(.WIDTH(W), .CHANNELS(CH), .CHW(CW)) bus();

    pwm_bank #(.WIDTH(W), .CHANNELS(CH), .CHW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_duty(input int ch, input int val);
        bus.duty_wr   = 1'b1;
        bus.duty_ch   = CW'(ch);
        bus.duty_data = W'(val);
        tick();
        bus.duty_wr   = 1'b0;
    endtask

    initial begin
        int         c;
        int         d;
        int         m;
        logic [3:0] e;

        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.period    = W'(9);
        bus.duty_wr   = 1'b0;
        bus.duty_ch   = '0;
        bus.duty_data = '0;
        tick();
        tick();
        check("rst_pwm", 32'(bus.pwm_out), 32'h0);
        check("rst_ps", 32'(bus.period_start), 32'h0);
        rst = 1'b0;

`ifdef PWM_BANK_CENTER_EN
        bus.period = W'(8);
        write_duty(0, 3);
        tick();
        check("dis_pwm", 32'(bus.pwm_out), 32'h0);
        bus.en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            m = k % 16;
            c = (m <= 8) ? m : 16 - m;
            e = {3'b000, (c < 3)};
            check("ctr_pwm", 32'(bus.pwm_out), 32'(e));
            check("ctr_ps", 32'(bus.period_start), 32'(c == 0));
        end
`else
        // ch0 = 3, ch1 = 0 (always low), ch2 = 10 and ch3 = 1023 (always high at period 9)
        write_duty(0, 3);
        write_duty(1, 0);
        write_duty(2, 10);
        write_duty(3, 1023);
        tick();
        check("dis_pwm", 32'(bus.pwm_out), 32'h0);
        check("dis_ps", 32'(bus.period_start), 32'h0);

        bus.en = 1'b1;
        for (int k = 0; k < 85; k++) begin
            bus.duty_wr = 1'b0;
            if (k == 24) begin
                bus.duty_wr = 1'b1; bus.duty_ch = CW'(0); bus.duty_data = W'(7);
            end else if (k == 39) begin
                bus.duty_wr = 1'b1; bus.duty_ch = CW'(0); bus.duty_data = W'(2);
            end else if (k == 45) begin
                bus.duty_wr = 1'b1; bus.duty_ch = CW'(5); bus.duty_data = W'(5);
            end else if (k == 46) begin
                bus.duty_wr = 1'b1; bus.duty_ch = CW'(4); bus.duty_data = W'(0);
            end
            if (k == 69) bus.period = W'(4);
            tick();
            c = (k < 70) ? (k % 10) : ((k - 70) % 5);
            d = (k < 30) ? 3 : ((k < 50) ? 7 : 2);
            e = {1'b1, 1'b1, 1'b0, (c < d)};
            check("edge_pwm", 32'(bus.pwm_out), 32'(e));
            check("edge_ps", 32'(bus.period_start), 32'(c == 0));
        end
        bus.duty_wr = 1'b0;

        // Reset mid-period, with a competing write that must be dropped.
        tick();
        tick();
        rst           = 1'b1;
        bus.duty_wr   = 1'b1;
        bus.duty_ch   = CW'(2);
        bus.duty_data = W'(9);
        tick();
        check("rstmid_pwm", 32'(bus.pwm_out), 32'h0);
        check("rstmid_ps", 32'(bus.period_start), 32'h0);
        rst         = 1'b0;
        bus.duty_wr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("postrst_pwm", 32'(bus.pwm_out), 32'h0);
            check("postrst_ps", 32'(bus.period_start), 32'(k % 5 == 0));
        end

        bus.period = '0;
        tick();
        write_duty(0, 5);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("p0_pwm", 32'(bus.pwm_out), 32'h1);
            check("p0_ps", 32'(bus.period_start), 32'h1);
        end

        bus.en = 1'b0;
        tick();
        check("en0_pwm", 32'(bus.pwm_out), 32'h0);
        check("en0_ps", 32'(bus.period_start), 32'h0);
        write_duty(1, 2);
        tick();
        bus.period = W'(9);
        bus.en     = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            e = {1'b0, 1'b0, (k < 2), (k < 5)};
            check("enrise_pwm", 32'(bus.pwm_out), 32'(e));
            check("enrise_ps", 32'(bus.period_start), 32'(k == 0));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
